// File: rtl/regfile_sb_if.sv
// Register-file/scoreboard bus between the pipeline (master) and regfile_sb (slave).
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            init_done;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rd1_data;
    logic [XLEN-1:0] rd2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            alloc_en;
    logic [AW-1:0]   alloc_addr;

    modport master (
        input  init_done, rd1_data, rd2_data, rs1_busy, rs2_busy,
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
    );

    modport slave (
        output init_done, rd1_data, rd2_data, rs1_busy, rs2_busy,
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-entry pending scoreboard and post-reset clear sweep.
// Optional same-cycle write-to-read bypass: define REGFILE_WRITE_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave bus
);

    typedef enum logic {INIT, READY} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic            sweep_we;

    logic [XLEN-1:0] regs    [NREGS];
    logic            pending [NREGS];

    logic            wr_ok;
    logic            alloc_ok;
    logic [AW-1:0]   rs_addr [2];
    logic [XLEN-1:0] rd      [2];
    logic [1:0]      busy;
    logic [1:0]      byp_hit;
    logic [1:0]      byp_clr;

    // Out-of-range addresses and the hardwired zero entry never hold state.
    function automatic logic live(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !(ZERO_REG && (a == '0));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_we  = 1'b0;
        case (state)
            INIT: begin
                sweep_we = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = READY;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            READY: begin
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign bus.init_done = (state == READY);

    assign wr_ok    = (state == READY) && bus.wr_en    && live(bus.wr_addr);
    assign alloc_ok = (state == READY) && bus.alloc_en && live(bus.alloc_addr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweep_we) begin
                regs[cnt] <= '0;
            end else if (wr_ok) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    // Alloc is applied after the writeback clear so a newly issued producer wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweep_we) begin
                pending[cnt] <= 1'b0;
            end else begin
                if (wr_ok) begin
                    pending[bus.wr_addr] <= 1'b0;
                end
                if (alloc_ok) begin
                    pending[bus.alloc_addr] <= 1'b1;
                end
            end
        end
    end

    assign rs_addr[0] = bus.rs1_addr;
    assign rs_addr[1] = bus.rs2_addr;

`ifdef REGFILE_WRITE_BYPASS_EN
    always_comb begin
        byp_hit = '0;
        byp_clr = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            byp_hit[p] = wr_ok && (bus.wr_addr == rs_addr[p]);
            byp_clr[p] = byp_hit[p] && !(alloc_ok && (bus.alloc_addr == rs_addr[p]));
        end
    end
`else
    assign byp_hit = '0;
    assign byp_clr = '0;
`endif

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd[p]   = '0;
            busy[p] = 1'b0;
            if ((state == READY) && live(rs_addr[p])) begin
                rd[p]   = byp_hit[p] ? bus.wr_data : regs[rs_addr[p]];
                busy[p] = pending[rs_addr[p]] && !byp_clr[p];
            end
        end
    end

    assign bus.rd1_data = rd[0];
    assign bus.rd2_data = rd[1];
    assign bus.rs1_busy = busy[0];
    assign bus.rs2_busy = busy[1];

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with an integrated scoreboard, for the pipelined core.
- Two combinational read ports and one write port.
- Entry 0 is optionally hardwired to zero.
- A pending bit per entry tracks in-flight producers so decode can detect RAW hazards.
- After reset, an init FSM clears all entries one per cycle and then raises init_done. No external preload file is used.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (2..64, need not be a power of 2)
AW, $clog2(NREGS), address width
ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes and is never busy

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clock clk
init_done  output  1  high once the clear sweep is complete
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rd1_data  output  XLEN  read port 1 data (combinational)
rd2_data  output  XLEN  read port 2 data (combinational)
rs1_busy  output  1  rs1 entry has an outstanding producer
rs2_busy  output  1  rs2 entry has an outstanding producer
wr_en  input  1  write strobe (writeback)
wr_addr  input  AW  write address
wr_data  input  XLEN  write data
alloc_en  input  1  mark an entry pending (issue of producing instruction)
alloc_addr  input  AW  entry to mark pending

Behaviour:
- FSM states: INIT, READY. A 6-bit-max sweep counter cnt (width AW) drives INIT.
- Reset, any cycle, including mid-sweep or in READY:
  - state<=INIT, cnt<=0, init_done<=0.
  - Register contents are undefined until the sweep has passed them.
- INIT, each edge without reset:
  - regs[cnt]<=0, pending[cnt]<=0.
  - If cnt==NREGS-1: state<=READY, init_done<=1. Otherwise cnt<=cnt+1.
  - init_done therefore rises on the NREGS-th edge after reset deasserts (32 by default).
- While in INIT:
  - wr_en and alloc_en are ignored.
  - rd1_data/rd2_data=0; rs1_busy/rs2_busy=0.
- READY, write: on an edge with wr_en, regs[wr_addr]<=wr_data and pending[wr_addr]<=0.
- READY, alloc: on an edge with alloc_en, pending[alloc_addr]<=1.
  - Alloc and write to the same address in one cycle: data is written and pending ends at 1 (alloc wins, since a newer producer was issued).
  - Alloc to an already-pending entry: stays 1, no error.
- Reads: rdN_data=regs[rsN_addr], subject to the bypass rules under Optional Feature.
  - rsN_busy=pending[rsN_addr], with the same-cycle clear rule under Optional Feature.
- ZERO_REG=1:
  - Address 0 reads 0 and busy=0 always.
  - Writes and allocs to address 0 are dropped and not bypassed.
- Address >= NREGS (non-power-of-2 NREGS): writes/allocs dropped; reads return 0, busy=0.
- Both read ports may address the same entry; they return identical values.
- No output is registered; read latency is 0 cycles, write-to-visible latency is 1 edge (0 with bypass).

Optional Feature:
Macro REGFILE_WRITE_BYPASS_EN.
- Defined, in READY:
  - If wr_en && wr_addr==rsN_addr and the entry is writable, rdN_data=wr_data in the same cycle.
  - rsN_busy is forced 0 in that cycle, unless alloc_en && alloc_addr==rsN_addr.
- Not defined:
  - Reads return the pre-edge register value.
  - rsN_busy reflects stored pending only.
  - The consumer sees the new value and cleared busy one cycle later.

Test Plan:
- Reset for 3 cycles, release -> init_done low for 31 edges and high after the 32nd; all 32 entries read 0, busy 0; wr_en to x5 during the sweep is ignored (x5 reads 0 after).
- READY: write x7=0xDEADBEEF, next cycle rs1=7, rs2=7 -> both return 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
- Same-cycle write x9=0xA5A5A5A5 with rs1=9 -> with REGFILE_WRITE_BYPASS_EN rd1_data=0xA5A5A5A5 that cycle; without it rd1_data=old value, new value next cycle.
- alloc x3, then rs2=3 -> rs2_busy=1; write x3=0x11 -> busy clears (same cycle with bypass, next without); simultaneous alloc x3 + write x3=0x22 -> x3=0x22, busy stays 1.
- NREGS=24: write addr 30 -> dropped, read addr 30 returns 0, init_done after 24 edges.
- Reset asserted mid-sweep at cnt=10 and again in READY after writes -> sweep restarts from 0, init_done drops, all entries 0 after a full sweep.
